rsa_operand_sequencer: RTL and testbench

//  Controller that sequences the 512-bit RSA core (r512-class datapath) from a word-serial host.

---
 rtl/rsa_operand_sequencer.sv | 152 +++++++++++++++
 tb/tb_rsa_operand_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_sequencer.sv
// Word-serial sequencer for the wide RSA core. It assembles the p/q operands from host beats,
// issues a one-cycle start pulse, waits for done with a timeout, and then streams the result out.
module rsa_operand_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_DATA   = 512,
  parameter int unsigned TIMEOUT    = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] p_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  output logic [MAX_DATA-1:0]   op_p,
  output logic [MAX_DATA-1:0]   op_q,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [MAX_DATA-1:0]   core_m,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] m_out,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned WORDS   = MAX_DATA / DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(WORDS + 1);
  localparam int unsigned TIMER_W = 32;

  localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(WORDS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
  localparam bit                 TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_UNLOAD,
    S_ERROR
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       word_cnt_q;
  logic [TIMER_W-1:0]     timer_q;
  logic [TIMER_W-1:0]     timer_d;
  logic [MAX_DATA-1:0]    op_p_q;
  logic [MAX_DATA-1:0]    op_q_q;
  logic [MAX_DATA-1:0]    result_q;
  logic [DATA_WIDTH-1:0]  m_out_q;
  logic                   in_ready_q;
  logic                   core_start_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   err_q;
  logic                   in_beat_c;
  logic                   out_beat_c;

  // Handshake qualifiers and saturating wait-timer increment
  assign in_beat_c  = in_valid && in_ready_q;
  assign out_beat_c = out_valid_q && out_ready;
  assign timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);

  // Sequencer state, operand/result shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      word_cnt_q   <= '0;
      timer_q      <= '0;
      op_p_q       <= '0;
      op_q_q       <= '0;
      result_q     <= '0;
      m_out_q      <= '0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_beat_c) begin
            // New word enters at the top so the first beat ends up least significant
            op_p_q <= {p_in, op_p_q[MAX_DATA-1:DATA_WIDTH]};
            op_q_q <= {q_in, op_q_q[MAX_DATA-1:DATA_WIDTH]};
            busy_q <= 1'b1;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q   <= '0;
              state_q      <= S_START;
              core_start_q <= 1'b1;
              in_ready_q   <= 1'b0;
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_d;
          // A done arriving on the final timeout cycle still counts as success
          if (core_done) begin
            result_q    <= core_m;
            m_out_q     <= core_m[DATA_WIDTH-1:0];
            out_valid_q <= 1'b1;
            state_q     <= S_UNLOAD;
          end else if (TIMEOUT_EN && (timer_q == TIMER_LIMIT)) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end
        end
        S_UNLOAD: begin
          if (out_beat_c) begin
            result_q <= {{DATA_WIDTH{1'b0}}, result_q[MAX_DATA-1:DATA_WIDTH]};
            m_out_q  <= result_q[2*DATA_WIDTH-1:DATA_WIDTH];
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q  <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_LOAD;
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        end
        S_ERROR: begin
          err_q       <= 1'b1;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign op_p       = op_p_q;
  assign op_q       = op_q_q;
  assign core_start = core_start_q;
  assign out_valid  = out_valid_q;
  assign m_out      = m_out_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Directed bench for rsa_operand_sequencer: dut_a uses the default timeout, dut_b uses a 50-cycle timeout.
module tb_rsa_operand_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         core_done;
  logic [31:0]  p_in;
  logic [31:0]  q_in;
  logic [511:0] core_m;

  logic         in_ready_a, core_start_a, out_valid_a, busy_a, err_a;
  logic [511:0] op_p_a, op_q_a;
  logic [31:0]  m_out_a;
  logic         in_ready_b, core_start_b, out_valid_b, busy_b, err_b;
  logic [511:0] op_p_b, op_q_b;
  logic [31:0]  m_out_b;

  int checks;
  int errors;
  int starts_a;

  rsa_operand_sequencer dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .p_in(p_in), .q_in(q_in), .op_p(op_p_a), .op_q(op_q_a),
    .core_start(core_start_a), .core_done(core_done), .core_m(core_m),
    .out_valid(out_valid_a), .out_ready(out_ready), .m_out(m_out_a),
    .busy(busy_a), .err(err_a)
  );

  rsa_operand_sequencer #(.TIMEOUT(50)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .p_in(p_in), .q_in(q_in), .op_p(op_p_b), .op_q(op_q_b),
    .core_start(core_start_b), .core_done(core_done), .core_m(core_m),
    .out_valid(out_valid_b), .out_ready(out_ready), .m_out(m_out_b),
    .busy(busy_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which dut_a holds core_start high
  always @(posedge clk) begin
    if (core_start_a === 1'b1) starts_a <= starts_a + 1;
  end

  function automatic logic [511:0] build_op(input logic [31:0] base);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  function automatic logic [511:0] build_result();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = 32'hA000 + 32'(k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
    p_in = '0; q_in = '0; core_m = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_in_ready: in_ready=%b required 1 within 10 cycles", in_ready_a);
    end
  endtask

  task automatic load_operand(input logic [31:0] pbase, input logic [31:0] qbase,
                              input bit gappy, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      p_in = pbase + 32'(i);
      q_in = qbase + 32'(i);
      tick();
      if (gappy && i < nbeats - 1) begin
        in_valid = 1'b0;
        p_in = 32'hDEAD_BEEF;
        q_in = 32'hBAD0_F00D;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
    p_in = '0; q_in = '0; core_m = '0;
    tick();
    checks++;
    if ({in_ready_a, core_start_a, out_valid_a, busy_a, err_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: ready/start/valid/busy/err=%b required 00000",
               {in_ready_a, core_start_a, out_valid_a, busy_a, err_a});
    end
    checks++;
    if (op_p_a !== '0 || op_q_a !== '0 || m_out_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: op_p[31:0]=%h op_q[31:0]=%h m_out=%h required 0",
               op_p_a[31:0], op_q_a[31:0], m_out_a);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready_a, busy_a);
    end
  endtask

  task automatic test_load_continuous();
    int s0;
    do_reset();
    wait_in_ready();
    s0 = starts_a;
    load_operand(32'h1, 32'h100, 1'b0, 16);
    checks++;
    if (core_start_a !== 1'b1 || in_ready_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL load_start: start/in_ready/busy=%b%b%b required 101",
               core_start_a, in_ready_a, busy_a);
    end
    checks++;
    if (op_p_a[31:0] !== 32'h1 || op_p_a[511:480] !== 32'h10 || op_q_a[31:0] !== 32'h100) begin
      errors++;
      $display("FAIL load_words: p_lo=%h p_hi=%h q_lo=%h required 1 10 100",
               op_p_a[31:0], op_p_a[511:480], op_q_a[31:0]);
    end
    checks++;
    if (op_p_a !== build_op(32'h1) || op_q_a !== build_op(32'h100)) begin
      errors++;
      $display("FAIL load_operand: op_p=%h required %h", op_p_a, build_op(32'h1));
    end
    tick();
    checks++;
    if (core_start_a !== 1'b0 || starts_a - s0 != 1) begin
      errors++;
      $display("FAIL load_pulse: start=%b pulses=%0d required 0 and 1", core_start_a, starts_a - s0);
    end
  endtask

  task automatic test_load_toggled();
    int s0;
    do_reset();
    wait_in_ready();
    s0 = starts_a;
    load_operand(32'h1, 32'h100, 1'b1, 16);
    checks++;
    if (core_start_a !== 1'b1) begin
      errors++;
      $display("FAIL toggle_start: start=%b required 1", core_start_a);
    end
    in_valid = 1'b1; p_in = 32'hFFFF_0000; q_in = 32'h0000_FFFF;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (starts_a - s0 != 1 || in_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL toggle_pulse: pulses=%0d in_ready=%b required 1 0", starts_a - s0, in_ready_a);
    end
    checks++;
    if (op_p_a !== build_op(32'h1) || op_q_a !== build_op(32'h100)) begin
      errors++;
      $display("FAIL toggle_operand: op_p=%h required %h", op_p_a, build_op(32'h1));
    end
  endtask

  task automatic test_unload();
    int idx;
    int stall;
    int n;
    do_reset();
    wait_in_ready();
    load_operand(32'h11, 32'h22, 1'b0, 16);
    for (int c = 0; c < 99; c++) tick();
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL unload_early: out_valid=%b required 0", out_valid_a);
    end
    core_done = 1'b1;
    core_m = build_result();
    tick();
    core_done = 1'b0;
    core_m = '0;
    checks++;
    if (out_valid_a !== 1'b1 || m_out_a !== 32'hA000) begin
      errors++;
      $display("FAIL unload_first: out_valid=%b m_out=%h required 1 a000", out_valid_a, m_out_a);
    end
    idx = 0; stall = 0; n = 0;
    while (idx < 16 && n < 64) begin
      out_ready = !(idx == 5 && stall < 3);
      if (!out_ready) stall++;
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || m_out_a !== 32'hA000 + 32'(idx)) begin
        errors++;
        $display("FAIL unload_beat%0d: out_valid=%b m_out=%h required 1 %h",
                 idx, out_valid_a, m_out_a, 32'hA000 + 32'(idx));
      end
      @(posedge clk);
      #1;
      if (out_ready) idx++;
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (idx != 16 || stall != 3) begin
      errors++;
      $display("FAIL unload_count: beats=%0d stalls=%0d required 16 3", idx, stall);
    end
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL unload_done: valid/in_ready/busy=%b%b%b required 010",
               out_valid_a, in_ready_a, busy_a);
    end
    checks++;
    if (op_p_a !== build_op(32'h11) || op_q_a !== build_op(32'h22)) begin
      errors++;
      $display("FAIL unload_operand_stable: op_p=%h required %h", op_p_a, build_op(32'h11));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wait_in_ready();
    load_operand(32'h3, 32'h4, 1'b0, 16);
    checks++;
    if (core_start_b !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: start=%b required 1", core_start_b);
    end
    for (int c = 0; c < 50; c++) tick();
    checks++;
    if (err_b !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%b required 0 at start+50", err_b);
    end
    tick();
    checks++;
    if (err_b !== 1'b1 || in_ready_b !== 1'b0 || out_valid_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: err/in_ready/valid/busy=%b%b%b%b required 1001",
               err_b, in_ready_b, out_valid_b, busy_b);
    end
    core_done = 1'b1;
    core_m = '1;
    in_valid = 1'b1; p_in = 32'h5555_5555; q_in = 32'h6666_6666;
    tick();
    core_done = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (err_b !== 1'b1 || out_valid_b !== 1'b0 || in_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err/valid/in_ready=%b%b%b required 100",
               err_b, out_valid_b, in_ready_b);
    end
    checks++;
    if (op_p_b !== build_op(32'h3) || op_q_b !== build_op(32'h4)) begin
      errors++;
      $display("FAIL timeout_operand: op_p=%h required %h", op_p_b, build_op(32'h3));
    end
    rst = 1'b1;
    tick();
    checks++;
    if (err_b !== 1'b0 || in_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rst: err=%b in_ready=%b required 0 0", err_b, in_ready_b);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: in_ready=%b busy=%b required 1 0", in_ready_b, busy_b);
    end
  endtask

  task automatic test_reset_mid_load();
    int s0;
    do_reset();
    wait_in_ready();
    load_operand(32'h500, 32'h600, 1'b0, 7);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: busy=%b required 1", busy_a);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (op_p_a !== '0 || op_q_a !== '0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: p_lo=%h busy=%b required 0 0", op_p_a[31:0], busy_a);
    end
    rst = 1'b0;
    wait_in_ready();
    s0 = starts_a;
    load_operand(32'h200, 32'h300, 1'b0, 15);
    checks++;
    if (core_start_a !== 1'b0 || starts_a != s0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_early: start=%b pulses=%0d in_ready=%b required 0 0 1",
               core_start_a, starts_a - s0, in_ready_a);
    end
    load_operand(32'h20F, 32'h30F, 1'b0, 1);
    checks++;
    if (core_start_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_start: start=%b required 1", core_start_a);
    end
    checks++;
    if (op_p_a !== build_op(32'h200) || op_q_a !== build_op(32'h300)) begin
      errors++;
      $display("FAIL midrst_operand: op_p=%h required %h", op_p_a, build_op(32'h200));
    end
  endtask

  task automatic test_done_edge();
    do_reset();
    wait_in_ready();
    core_done = 1'b1;
    core_m = build_result();
    tick();
    core_done = 1'b0;
    tick();
    checks++;
    if (out_valid_b !== 1'b0 || busy_b !== 1'b0 || in_ready_b !== 1'b1 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL done_in_load: valid/busy/in_ready/err=%b%b%b%b required 0010",
               out_valid_b, busy_b, in_ready_b, err_b);
    end
    load_operand(32'h5, 32'h6, 1'b0, 16);
    for (int c = 0; c < 50; c++) tick();
    checks++;
    if (err_b !== 1'b0 || out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL edge_pre: err=%b valid=%b required 0 0", err_b, out_valid_b);
    end
    core_done = 1'b1;
    core_m = build_result();
    tick();
    core_done = 1'b0;
    core_m = '0;
    checks++;
    if (out_valid_b !== 1'b1 || err_b !== 1'b0 || m_out_b !== 32'hA000) begin
      errors++;
      $display("FAIL edge_done: valid=%b err=%b m_out=%h required 1 0 a000",
               out_valid_b, err_b, m_out_b);
    end
    tick();
    tick();
    checks++;
    if (out_valid_b !== 1'b1 || err_b !== 1'b0 || m_out_b !== 32'hA000) begin
      errors++;
      $display("FAIL edge_hold: valid=%b err=%b m_out=%h required 1 0 a000",
               out_valid_b, err_b, m_out_b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    starts_a = 0;
    test_reset();
    test_load_continuous();
    test_load_toggled();
    test_unload();
    test_timeout();
    test_reset_mid_load();
    test_done_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
